fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write-port arbiter for the dual-clock FIFO; lives entirely in the wr_clk domain.
//   Shares one FIFO write port (wr_en/data_in/full) among NREQ producers.
//   Grants bursts of up to BURST words and never issues a write while the FIFO reports full.
//   Requesters present first-word-fall-through data; req_ack is their pop strobe.
// PARAMETERS
//   NREQ   4    number of requesters (>=2)
//   DW     16   data width, equal to the FIFO data_in width
//   BURST  8    max words per grant before forced re-arbitration (>=1)
// PORTS
//   wr_clk     in   1           write-domain clock; all logic on rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   req        in   NREQ        req[i]=1: requester i has a valid word on its data slice
//   req_data   in   NREQ*DW     requester i word at [i*DW +: DW]
//   req_ack    out  NREQ        one-hot; word from requester i consumed this cycle
//   fifo_full  in   1           FIFO full flag (wr_clk domain)
//   fifo_wr_en out  1           FIFO write strobe
//   fifo_din   out  DW          FIFO write data
//   gnt_id     out  clog2(NREQ) current or most recent owner index
//   busy       out  1           1 while a grant is held (state XFER)
//   word_cnt   out  16          total words written since reset, wraps at 2^16
// BEHAVIOUR
// - Reset: state IDLE, owner=NREQ-1 (gnt_id=NREQ-1), beat=0, word_cnt=0. fifo_wr_en, req_ack and busy are 0, and fifo_din is 0.
// - Reset assertion mid-burst forces these values immediately (async). No partial word is written after rst_n falls.
// - FSM, two states:
//   - IDLE: if |req, pick the first i with req[i]=1, scanning owner+1, owner+2, ... mod NREQ.
//     - Register owner=i, clear beat, go to XFER next edge.
//     - If no req, stay in IDLE.
//     - Arbitration costs 1 cycle; nothing is written in IDLE.
//   - XFER: xfer = req[owner] & ~fifo_full.
//     - xfer=1: fifo_wr_en=1, fifo_din=req_data[owner], req_ack[owner]=1. All are combinational from registered owner/state, same cycle.
//     - On an xfer edge: beat++ and word_cnt++.
//     - If beat==BURST-1 on an xfer edge: go IDLE (burst done).
//     - req[owner]=0 (regardless of full): go IDLE. No write that cycle.
//     - fifo_full=1 with req[owner]=1: stall. Hold grant and beat, no timeout.
// - Outside an xfer cycle: fifo_wr_en=0, req_ack=0, fifo_din=0.
// - Invariant: fifo_wr_en & fifo_full is never 1. req_ack equals fifo_wr_en one-hot-decoded by owner.
// - Peak throughput: BURST words per BURST+1 cycles for continuous requesters.
// - busy=1 exactly in XFER. gnt_id holds its value after release until the next grant.
// - beat width is clog2(BURST)+1. word_cnt wraps 0xFFFF -> 0x0000 without a flag.
// - req changing in IDLE affects only the next arbitration. A new req arriving during XFER waits for release.
// TESTING
// - Only req[2] high, 20 words 0x100.., full=0:
//   - Expect bursts of 8, 8, 4, gnt_id=2, a 1-cycle busy=0 gap between bursts.
//   - Expect 20 in-order writes 0x100-0x113; word_cnt=20.
// - All req high continuously, full=0:
//   - Expect grant order 0,1,2,3,0 with 8 writes each.
//   - Expect each ack pattern one-hot on the owner only.
// - req[1] streaming, fifo_full=1 for 5 cycles after its 3rd write:
//   - Expect fifo_wr_en=req_ack=0 for those 5 cycles, busy=1.
//   - Expect the burst to resume and end after 5 more writes (8 total).
// - req[0] drops after 3 words while req[3] is high: release, then 1 IDLE cycle, then gnt_id=3 with a full 8-word burst.
// - rst_n pulled low mid-burst (owner=2, beat=4):
//   - Expect outputs 0 immediately and word_cnt=0.
//   - After release with all req high, expect the first grant to go to requester 0.
// - Preload: 65535 writes, then 2 more: word_cnt reads 0xFFFF, then 0x0000, then 0x0001.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of signals shared by the write-port arbiter, its producers and the FIFO write port.
// The arbiter uses the slave view; the producer/FIFO environment uses the master view.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ack;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_din;
  logic [IDW-1:0]     gnt_id;
  logic               busy;
  logic [15:0]        word_cnt;

  modport master (
    output req, req_data, fifo_full,
    input  req_ack, fifo_wr_en, fifo_din, gnt_id, busy, word_cnt
  );

  modport slave (
    input  req, req_data, fifo_full,
    output req_ack, fifo_wr_en, fifo_din, gnt_id, busy, word_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ first-word-fall-through
// producers. A grant lasts at most BURST words; writes are suppressed while the FIFO is full.
// Everything runs in the wr_clk domain.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 16,
  parameter int BURST = 8
) (
  input  logic               wr_clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW  = $clog2(BURST) + 1;

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_owner;
  logic [BW-1:0]   r_beat;
  logic [15:0]     r_word_cnt;

  logic [IDW-1:0]  w_next_owner;
  logic            w_owner_req;
  logic            w_xfer;

  // First requester after 'last' in circular order; 'last' itself is checked last.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req_vec,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    int             idx;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req_vec[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  // Next owner candidate computed from the registered owner.
  always_comb begin
    w_next_owner = rr_pick(bus.req, r_owner);
  end

  assign w_owner_req = bus.req[r_owner];
  assign w_xfer      = (r_state == S_XFER) & w_owner_req & ~bus.fifo_full;

  assign bus.fifo_wr_en = w_xfer;
  assign bus.fifo_din   = w_xfer ? bus.req_data[int'(r_owner)*DW +: DW] : '0;
  assign bus.req_ack    = w_xfer ? (NREQ'(1) << r_owner) : '0;
  assign bus.busy       = (r_state == S_XFER);
  assign bus.gnt_id     = r_owner;
  assign bus.word_cnt   = r_word_cnt;

  // Arbitration FSM: grant in IDLE, stream up to BURST words in XFER, release on drop or burst end.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_owner    <= IDW'(NREQ - 1);
      r_beat     <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_owner <= w_next_owner;
            r_beat  <= '0;
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          if (!w_owner_req) begin
            // Producer ran dry: give the port back without writing.
            r_state <= S_IDLE;
          end else if (!bus.fifo_full) begin
            r_beat     <= r_beat + 1'b1;
            r_word_cnt <= r_word_cnt + 16'd1;
            if (r_beat == BW'(BURST - 1)) r_state <= S_IDLE;
          end
          // Full with data pending: hold grant and beat until space appears.
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues drive the requests, a transaction-level
// model predicts every output on each falling edge, and directed scenarios pin
// burst lengths, grant order, stall behaviour, reset and counter wrap with literals.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 16;
  localparam int BURST = 8;

  logic wr_clk = 1'b0;
  logic rst_n  = 1'b0;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
    .wr_clk (wr_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // ---------------- producers ----------------
  int          src_len  [NREQ];
  int          src_sent [NREQ];
  logic [15:0] src_base [NREQ];

  logic [NREQ-1:0] s_ack;
  logic            s_wr;
  logic            s_busy;

  // ---------------- counters ----------------
  int n_chk_m  = 0;
  int n_fail_m = 0;
  int n_chk_d  = 0;
  int n_fail_d = 0;

  // ---------------- write log / burst bookkeeping ----------------
  typedef struct {
    int              burst;
    int              owner;
    logic [15:0]     data;
    logic [NREQ-1:0] ack;
  } wr_t;

  wr_t wlog[$];
  int  gaps[$];
  int  burst_no;
  int  idle_run;
  bit  seen_end;
  bit  prev_busy;
  bit  log_en = 1'b1;

  // ---------------- model state ----------------
  bit     m_hold;
  int     m_who;
  int     m_left;
  longint m_total;

  logic            e_wr;
  logic [15:0]     e_din;
  logic [NREQ-1:0] e_ack;
  int              e_gnt;
  logic            e_busy;
  logic [15:0]     e_cnt;
  bit              m_found;
  int              m_cand;

  // Model: predict outputs from the current inputs, compare, then advance across the coming edge.
  always @(negedge wr_clk) begin
    if (!rst_n) begin
      m_hold    = 1'b0;
      m_who     = NREQ - 1;
      m_left    = 0;
      m_total   = 0;
      wlog.delete();
      gaps.delete();
      burst_no  = 0;
      idle_run  = 0;
      seen_end  = 1'b0;
      prev_busy = 1'b0;
    end

    e_busy = m_hold;
    e_gnt  = m_who;
    e_wr   = m_hold && bus.req[m_who] && !bus.fifo_full;
    e_din  = e_wr ? bus.req_data[m_who*DW +: DW] : 16'h0;
    e_ack  = e_wr ? (NREQ'(1) << m_who) : '0;
    e_cnt  = 16'(m_total % 65536);

    n_chk_m++;
    if (bus.fifo_wr_en !== e_wr || bus.fifo_din !== e_din || bus.req_ack !== e_ack ||
        int'(bus.gnt_id) != e_gnt || bus.busy !== e_busy || bus.word_cnt !== e_cnt ||
        (bus.fifo_wr_en & bus.fifo_full) !== 1'b0) begin
      n_fail_m++;
      if (n_fail_m <= 20)
        $display("FAIL model_cmp t=%0t act/exp wr=%b/%b din=%h/%h ack=%b/%b gnt=%0d/%0d busy=%b/%b cnt=%h/%h full=%b",
                 $time, bus.fifo_wr_en, e_wr, bus.fifo_din, e_din, bus.req_ack, e_ack,
                 bus.gnt_id, e_gnt, bus.busy, e_busy, bus.word_cnt, e_cnt, bus.fifo_full);
    end

    if (rst_n) begin
      if (bus.fifo_wr_en && log_en)
        wlog.push_back('{burst_no, int'(bus.gnt_id), bus.fifo_din, bus.req_ack});
      if (bus.busy) begin
        if (!prev_busy && seen_end) gaps.push_back(idle_run);
        idle_run = 0;
      end else begin
        if (prev_busy) begin
          burst_no++;
          seen_end = 1'b1;
        end
        idle_run++;
      end
      prev_busy = bus.busy;

      if (!m_hold) begin
        if (bus.req != '0) begin
          m_found = 1'b0;
          for (int k = 1; k <= NREQ; k++) begin
            m_cand = (m_who + k) % NREQ;
            if (!m_found && bus.req[m_cand]) begin
              m_found = 1'b1;
              m_who   = m_cand;
            end
          end
          m_hold = 1'b1;
          m_left = BURST;
        end
      end else if (!bus.req[m_who]) begin
        m_hold = 1'b0;
      end else if (!bus.fifo_full) begin
        m_total++;
        m_left--;
        if (m_left == 0) m_hold = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk_d++;
    if (act != exp) begin
      n_fail_d++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i] = (src_sent[i] < src_len[i]);
      bus.req_data[i*DW +: DW] = src_base[i] + 16'(src_sent[i]);
    end
  endtask

  task automatic step();
    @(negedge wr_clk);
    s_ack  = bus.req_ack;
    s_wr   = bus.fifo_wr_en;
    s_busy = bus.busy;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (s_ack[i]) src_sent[i]++;
    drive_src();
  endtask

  task automatic clear_src();
    for (int i = 0; i < NREQ; i++) begin
      src_len[i]  = 0;
      src_sent[i] = 0;
      src_base[i] = 16'h0;
    end
    bus.fifo_full = 1'b0;
    drive_src();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_src();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_bursts(input int n, input int budget, input string name);
    int c = 0;
    while (burst_no < n && c < budget) begin
      step();
      c++;
    end
    chk({name, "_done"}, longint'(burst_no >= n), 1);
  endtask

  function automatic int wr_in_burst(input int b);
    int n = 0;
    foreach (wlog[k]) if (wlog[k].burst == b) n++;
    return n;
  endfunction

  int order[5] = '{0, 1, 2, 3, 0};
  int cyc;

  initial begin
    // Reset state
    do_reset();
    chk("rst_gnt",  bus.gnt_id,     NREQ - 1);
    chk("rst_busy", bus.busy,       0);
    chk("rst_cnt",  bus.word_cnt,   0);
    chk("rst_wr",   bus.fifo_wr_en, 0);

    // Single requester, 20 words: bursts of 8, 8, 4 with 1-cycle gaps
    src_len[2] = 20; src_base[2] = 16'h0100; drive_src();
    run_bursts(3, 60, "t1");
    chk("t1_nwr", wlog.size(), 20);
    foreach (wlog[k]) begin
      chk($sformatf("t1_data%0d", k), wlog[k].data, 16'h0100 + k);
      chk($sformatf("t1_own%0d", k),  wlog[k].owner, 2);
    end
    chk("t1_b0", wr_in_burst(0), 8);
    chk("t1_b1", wr_in_burst(1), 8);
    chk("t1_b2", wr_in_burst(2), 4);
    chk("t1_ngaps", longint'(gaps.size() >= 2), 1);
    if (gaps.size() >= 2) begin
      chk("t1_gap0", gaps[0], 1);
      chk("t1_gap1", gaps[1], 1);
    end
    chk("t1_cnt", bus.word_cnt, 20);
    chk("t1_gnt", bus.gnt_id, 2);

    // All requesters busy: rotation 0,1,2,3,0 with 8 writes each
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      src_len[i] = 1000; src_base[i] = 16'(i * 16'h1000);
    end
    drive_src();
    run_bursts(5, 80, "t2");
    chk("t2_nwr", wlog.size(), 40);
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("t2_len%0d", b), wr_in_burst(b), 8);
      if (wlog.size() > b * 8)
        chk($sformatf("t2_own%0d", b), wlog[b*8].owner, order[b]);
    end
    foreach (wlog[k])
      chk($sformatf("t2_ack%0d", k), wlog[k].ack, NREQ'(1) << wlog[k].owner);

    // FIFO full for 5 cycles after the 3rd write of requester 1
    do_reset();
    src_len[1] = 100; src_base[1] = 16'h0200; drive_src();
    cyc = 0;
    while (wlog.size() < 3 && cyc < 20) begin step(); cyc++; end
    chk("t3_pre", wlog.size(), 3);
    bus.fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      chk($sformatf("t3_stall_wr%0d", s),   s_wr,   0);
      chk($sformatf("t3_stall_ack%0d", s),  s_ack,  0);
      chk($sformatf("t3_stall_busy%0d", s), s_busy, 1);
    end
    bus.fifo_full = 1'b0;
    run_bursts(1, 30, "t3");
    chk("t3_len", wr_in_burst(0), 8);
    chk("t3_nwr", wlog.size(), 8);
    if (wlog.size() == 8) chk("t3_last", wlog[7].data, 16'h0207);

    // Requester 0 runs dry after 3 words, requester 3 takes over after one IDLE cycle
    do_reset();
    src_len[0] = 3;   src_base[0] = 16'h0300;
    src_len[3] = 100; src_base[3] = 16'h0400;
    drive_src();
    run_bursts(2, 40, "t4");
    chk("t4_b0", wr_in_burst(0), 3);
    chk("t4_b1", wr_in_burst(1), 8);
    chk("t4_nwr", wlog.size(), 11);
    if (wlog.size() == 11) begin
      chk("t4_own0", wlog[0].owner, 0);
      chk("t4_own1", wlog[3].owner, 3);
      chk("t4_data", wlog[3].data, 16'h0400);
    end
    if (gaps.size() >= 1) chk("t4_gap", gaps[0], 1);
    else chk("t4_gap_seen", gaps.size(), 1);

    // Asynchronous reset mid-burst (owner 2, beat 4)
    do_reset();
    src_len[2] = 100; src_base[2] = 16'h0500; drive_src();
    cyc = 0;
    while (wlog.size() < 4 && cyc < 20) begin step(); cyc++; end
    chk("t5_pre_n", wlog.size(), 4);
    chk("t5_pre_wr", bus.fifo_wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_wr",   bus.fifo_wr_en, 0);
    chk("t5_ack",  bus.req_ack,    0);
    chk("t5_din",  bus.fifo_din,   0);
    chk("t5_busy", bus.busy,       0);
    chk("t5_cnt",  bus.word_cnt,   0);
    chk("t5_gnt",  bus.gnt_id,     NREQ - 1);
    for (int i = 0; i < NREQ; i++) begin
      src_len[i] = 100; src_sent[i] = 0; src_base[i] = 16'(16'h0600 + i * 16'h0100);
    end
    drive_src();
    step();
    step();
    rst_n = 1'b1;
    cyc = 0;
    while (wlog.size() < 1 && cyc < 10) begin step(); cyc++; end
    chk("t5_post_n", longint'(wlog.size() >= 1), 1);
    if (wlog.size() >= 1) begin
      chk("t5_first_own",  wlog[0].owner, 0);
      chk("t5_first_data", wlog[0].data,  16'h0600);
    end

    // word_cnt wrap after 65535 writes
    do_reset();
    log_en = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      src_len[i] = 32'h7fffffff; src_base[i] = 16'(i * 16'h1000);
    end
    drive_src();
    cyc = 0;
    while (bus.word_cnt != 16'hFFFF && cyc < 80000) begin step(); cyc++; end
    chk("t6_ffff", bus.word_cnt, 16'hFFFF);
    chk("t6_model_total", m_total, 65535);
    cyc = 0;
    while (bus.word_cnt == 16'hFFFF && cyc < 5) begin step(); cyc++; end
    chk("t6_wrap0", bus.word_cnt, 16'h0000);
    cyc = 0;
    while (bus.word_cnt == 16'h0000 && cyc < 5) begin step(); cyc++; end
    chk("t6_wrap1", bus.word_cnt, 16'h0001);

    $display("%0d/%0d checks passed",
             (n_chk_m + n_chk_d) - (n_fail_m + n_fail_d), n_chk_m + n_chk_d);
    $finish;
  end
endmodule
